// File: rtl/quan_sa_pkg.sv
// Shared types and helpers for the quantised systolic-array tile controller.
package quan_sa_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      FEED  = 2'd2,
      FLUSH = 2'd3
   } sa_state_t;

   localparam logic [3:0] MODE_U8I8 = 4'd0;
   localparam logic [3:0] MODE_U8T2 = 4'd1;

   // Flat bit position of cell (i,j) in the per-cell control vectors.
   function automatic int cell_idx(input int i, input int j, input int cols);
      return i * cols + j;
   endfunction

endpackage

// File: rtl/quan_sa_diag_shift.sv
// Reset-cleared delay line; stage[n] is the seed delayed n+1 cycles.
module quan_sa_diag_shift #(
   parameter int DEPTH = 31
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             seed,
   output logic [DEPTH-1:0] stage
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage <= '0;
      end else begin
         stage[0] <= seed;
         for (int n = 1; n < DEPTH; n++) stage[n] <= stage[n-1];
      end
   end

endmodule

// File: rtl/quan_sa_tile_ctrl.sv
// Tile sequencer for a ROWS x COLS systolic array: diagonal-wavefront cell
// controls, per-tile mode latching, same-mode tile overlap and result window.
module quan_sa_tile_ctrl
   import quan_sa_pkg::*;
#(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int K_W       = 12,
   parameter int DRAIN_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tile_valid,
   output logic                 tile_ready,
   input  logic [K_W-1:0]       tile_k,
   input  logic [3:0]           tile_mode,
   input  logic                 tile_mult,
   output logic [3:0]           mode,
   output logic                 mult_array_mode,
   output logic                 feed_en,
   output logic [ROWS*COLS-1:0] cell_clr,
   output logic [ROWS*COLS-1:0] cell_en,
   output logic [ROWS*COLS-1:0] cell_out_en,
   output logic                 res_valid,
   output logic                 tile_done,
   output logic                 busy
);

   localparam int DIAG    = ROWS + COLS - 1;
   localparam int RES_DLY = COLS + DRAIN_LAT;
   localparam int CNT_W   = $clog2(ROWS + 1);
   localparam logic [K_W-1:0] K_MIN = (ROWS > 2) ? K_W'(ROWS - 2) : '0;

   sa_state_t          state;
   logic [K_W-1:0]     feed_cnt;
   logic [K_W-1:0]     k_eff;
   logic               clr_seed, en_seed, oen_seed;
   logic               accept, pipe_empty, same_cfg;
   logic [DIAG-1:0]    clr_stage, en_stage, oen_stage;
   logic [RES_DLY-1:0] res_dly;
   logic [CNT_W-1:0]   win_cnt;

   assign k_eff    = (tile_k == '0) ? K_W'(1) : tile_k;
   assign clr_seed = (state == CLEAR);
   assign en_seed  = (state == FEED);
   assign oen_seed = (state == FLUSH);
   assign feed_en  = en_seed;

   // The FLUSH seed counts as in flight, so a mode change never overlaps it.
   assign pipe_empty = !oen_seed && (res_dly == '0) && (win_cnt == '0);
   // K >= ROWS-2 keeps the next ROWS-cycle result window clear of this one.
   assign same_cfg   = (tile_mode == mode) && (tile_mult == mult_array_mode) &&
                       (k_eff >= K_MIN);
   assign tile_ready = reset_n && ((state == IDLE) || (state == FLUSH)) &&
                       (pipe_empty || same_cfg);
   assign accept     = tile_valid && tile_ready;
   assign busy       = (state != IDLE) || !pipe_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         feed_cnt        <= '0;
         mode            <= '0;
         mult_array_mode <= 1'b0;
      end else begin
         if (accept) begin
            mode            <= tile_mode;
            mult_array_mode <= tile_mult;
            feed_cnt        <= k_eff;
         end
         case (state)
            IDLE:  if (accept) state <= CLEAR;
            CLEAR: state <= FEED;
            FEED: begin
               if (feed_cnt == K_W'(1)) state <= FLUSH;
               else                     feed_cnt <= feed_cnt - K_W'(1);
            end
            FLUSH:   state <= accept ? CLEAR : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   quan_sa_diag_shift #(.DEPTH(DIAG)) u_clr_shift (
      .clk(clk), .reset_n(reset_n), .seed(clr_seed), .stage(clr_stage)
   );
   quan_sa_diag_shift #(.DEPTH(DIAG)) u_en_shift (
      .clk(clk), .reset_n(reset_n), .seed(en_seed), .stage(en_stage)
   );
   quan_sa_diag_shift #(.DEPTH(DIAG)) u_oen_shift (
      .clk(clk), .reset_n(reset_n), .seed(oen_seed), .stage(oen_stage)
   );

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         localparam int IDX = cell_idx(i, j, COLS);
         assign cell_clr[IDX]    = clr_stage[i+j];
         assign cell_en[IDX]     = en_stage[i+j];
         assign cell_out_en[IDX] = oen_stage[i+j];
      end
   end

   // Result window: FLUSH pulse aligned to the packer output, then stretched to ROWS cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_dly <= '0;
         win_cnt <= '0;
      end else begin
         res_dly[0] <= oen_seed;
         for (int n = 1; n < RES_DLY; n++) res_dly[n] <= res_dly[n-1];
         if (res_dly[RES_DLY-1])  win_cnt <= CNT_W'(ROWS - 1);
         else if (win_cnt != '0)  win_cnt <= win_cnt - CNT_W'(1);
      end
   end

   assign res_valid = res_dly[RES_DLY-1] || (win_cnt != '0);
   assign tile_done = (ROWS == 1) ? res_dly[RES_DLY-1] : (win_cnt == CNT_W'(1));

endmodule

// File: tb/tb_quan_sa_tile_ctrl.sv
// Scoreboard bench for quan_sa_tile_ctrl at ROWS=COLS=4, DRAIN_LAT=2.
module tb_quan_sa_tile_ctrl;
   localparam int ROWS = 4, COLS = 4, K_W = 12, DRAIN_LAT = 2;

   logic                 clk = 1'b0, reset_n = 1'b0;
   logic                 tile_valid = 1'b0, tile_mult = 1'b0;
   logic [K_W-1:0]       tile_k = '0;
   logic [3:0]           tile_mode = '0;
   logic                 tile_ready, mult_array_mode, feed_en;
   logic                 res_valid, tile_done, busy;
   logic [3:0]           mode;
   logic [ROWS*COLS-1:0] cell_clr, cell_en, cell_out_en;

   typedef struct { int cyc; logic done; logic [3:0] mode; } exp_t;
   exp_t exp_q[$];
   int cyc = 0, errors = 0, checks = 0;
   int t0, acc_rel;

   quan_sa_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .DRAIN_LAT(DRAIN_LAT)) dut (
      .clk(clk), .reset_n(reset_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_k(tile_k), .tile_mode(tile_mode), .tile_mult(tile_mult), .mode(mode),
      .mult_array_mode(mult_array_mode), .feed_en(feed_en), .cell_clr(cell_clr),
      .cell_en(cell_en), .cell_out_en(cell_out_en), .res_valid(res_valid),
      .tile_done(tile_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int k, input logic [3:0] m, input logic mu);
      tile_valid = v; tile_k = K_W'(k); tile_mode = m; tile_mult = mu;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic push_exp(input int at, input logic [3:0] m);
      for (int r = 0; r < ROWS; r++) exp_q.push_back('{at + r, (r == ROWS - 1), m});
   endtask

   // Offer a tile until accepted; t0 is the accept cycle, results expected at t0+off.
   task automatic start_tile(input int k, input logic [3:0] m, input logic mu, input int off,
                             output int t_acc);
      int n = 0;
      next_cycle();
      drive(1'b1, k, m, mu);
      @(negedge clk);
      while (!tile_ready && n < 50) begin n++; @(negedge clk); end
      chk("start_ready", tile_ready, 1);
      t_acc = cyc;
      if (tile_ready) push_exp(cyc + off, m);
   endtask

   task automatic wait_idle();
      int n = 0;
      next_cycle();
      drive(1'b0, 0, 4'd0, 1'b0);
      @(negedge clk);
      while (busy && n < 100) begin n++; @(negedge clk); end
      chk("idle_timeout", busy, 0);
   endtask

   // Monitor: every result beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset_n) begin
         if (res_valid) begin
            if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("res_cycle", cyc, e.cyc);
               chk("res_done", tile_done, e.done);
               chk("res_mode", mode, e.mode);
            end
         end else if (tile_done) begin
            chk("done_without_valid", 1, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #3;
      chk("rst_ready", tile_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mode", mode, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_cells", |{cell_clr, cell_en, cell_out_en}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      #1 chk("post_rst_ready", tile_ready, 1);

      // Same-mode back-to-back K=5 tiles: second accepted in FLUSH.
      start_tile(5, 4'd0, 1'b0, 13, t0);
      acc_rel = -1;
      for (int rel = 1; rel <= 24; rel++) begin
         next_cycle();
         if (acc_rel < 0) drive(1'b1, 5, 4'd0, 1'b0);
         else             drive(1'b0, 0, 4'd0, 1'b0);
         @(negedge clk);
         chk("clr00", cell_clr[0], (rel == 2 || rel == 9));
         chk("clr33", cell_clr[15], (rel == 8 || rel == 15));
         chk("en00", cell_en[0], ((rel >= 3 && rel <= 7) || (rel >= 10 && rel <= 14)));
         chk("oen00", cell_out_en[0], (rel == 8 || rel == 15));
         chk("oen33", cell_out_en[15], (rel == 14 || rel == 21));
         if (rel <= 7) chk("ready_b2b", tile_ready, (rel == 7));
         if (rel == 1) chk("feed_in_clear", feed_en, 0);
         if (rel == 2) chk("feed_in_feed", feed_en, 1);
         if (acc_rel < 0 && tile_valid && tile_ready) begin
            acc_rel = rel;
            push_exp(cyc + 13, 4'd0);
         end
      end
      chk("b2b_accept_rel", acc_rel, 7);
      wait_idle();

      // Mode change offered in FLUSH waits for the full drain.
      start_tile(5, 4'd0, 1'b0, 13, t0);
      acc_rel = -1;
      for (int rel = 1; rel <= 20; rel++) begin
         next_cycle();
         if (rel >= 7 && acc_rel < 0) drive(1'b1, 5, 4'd1, 1'b0);
         else                         drive(1'b0, 0, 4'd0, 1'b0);
         @(negedge clk);
         if (rel >= 7 && rel <= 17) chk("ready_modechg", tile_ready, (rel == 17));
         if (rel == 17) chk("mode_before", mode, 0);
         if (rel == 18) chk("mode_after", mode, 1);
         if (acc_rel < 0 && tile_valid && tile_ready) begin
            acc_rel = rel;
            push_exp(cyc + 13, 4'd1);
         end
      end
      chk("modechg_accept_rel", acc_rel, 17);
      wait_idle();

      // Same-mode K=1 in FLUSH violates the K rule, so it waits for pipe_empty.
      start_tile(5, 4'd1, 1'b0, 13, t0);
      acc_rel = -1;
      for (int rel = 1; rel <= 20; rel++) begin
         next_cycle();
         if (rel >= 7 && acc_rel < 0) drive(1'b1, 1, 4'd1, 1'b0);
         else                         drive(1'b0, 0, 4'd1, 1'b0);
         @(negedge clk);
         if (rel >= 7 && rel <= 17) chk("ready_shortk", tile_ready, (rel == 17));
         if (acc_rel < 0 && tile_valid && tile_ready) begin
            acc_rel = rel;
            push_exp(cyc + 9, 4'd1);
         end
      end
      chk("shortk_accept_rel", acc_rel, 17);
      wait_idle();

      // tile_k=0 acts as K=1.
      start_tile(0, 4'd0, 1'b0, 9, t0);
      for (int rel = 1; rel <= 6; rel++) begin
         next_cycle();
         drive(1'b0, 0, 4'd0, 1'b0);
         @(negedge clk);
         chk("k0_clr00", cell_clr[0], (rel == 2));
         chk("k0_en00", cell_en[0], (rel == 3));
         chk("k0_feed", feed_en, (rel == 2));
         chk("k0_oen00", cell_out_en[0], (rel == 4));
      end
      wait_idle();

      // Reset during FEED: everything clears at once, no result window.
      start_tile(5, 4'd1, 1'b1, 13, t0);
      for (int rel = 1; rel <= 3; rel++) begin
         next_cycle();
         drive(1'b0, 0, 4'd0, 1'b0);
         @(negedge clk);
      end
      chk("pre_rst_feed", feed_en, 1);
      chk("pre_rst_mode", mode, 1);
      chk("pre_rst_mult", mult_array_mode, 1);
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_feed", feed_en, 0);
      chk("mid_rst_cells", |{cell_clr, cell_en, cell_out_en}, 0);
      chk("mid_rst_res", {res_valid, tile_done}, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mode", {mode, mult_array_mode}, 0);
      chk("mid_rst_ready", tile_ready, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel_ready", tile_ready, 1);
      chk("rel_busy", busy, 0);
      repeat (25) @(negedge clk);
      chk("late_busy", busy, 0);
      chk("late_ready", tile_ready, 1);
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/quan_sa_tile_ctrl.md
# quan_sa_tile_ctrl

Parametrised tile sequencer for the quantised systolic array (SA). It accepts one tile command at a time and emits the diagonal-wavefront cell clear, enable and output-enable controls for any ROWS×COLS array, replacing fixed 16×16 per-cell OR-rolled control. It also latches the operating mode per tile instead of only at reset, and overlaps consecutive same-mode tiles. It signals when drained results are valid at the SA output packer.

## Interface
- ROWS, 16, SA rows
- COLS, 16, SA columns
- K_W, 12, width of the accumulation-length field
- DRAIN_LAT, 2, cycles from the column-deskew input to the packed output (delay regs plus output register)
- clk  in  1  clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- tile_valid  in  1  tile command valid
- tile_ready  out  1  tile command accepted when tile_valid && tile_ready
- tile_k  in  K_W  accumulation cycles; 0 is treated as 1
- tile_mode  in  4  0 = uint8×int8, 1 = uint8×2-bit packed; others select zero operands
- tile_mult  in  1  mult_array_mode for row 0
- mode  out  4  current SA mode; reset 0
- mult_array_mode  out  1  reset 0
- feed_en  out  1  operand feeders present the next row/column word next cycle; reset 0
- cell_clr  out  ROWS*COLS  per-cell accumulator clear; bit i*COLS+j; reset 0
- cell_en  out  ROWS*COLS  per-cell accumulate enable; reset 0
- cell_out_en  out  ROWS*COLS  per-cell result-load enable; reset 0
- res_valid  out  1  packed SA output word valid; reset 0
- tile_done  out  1  one-cycle pulse on the last res_valid of a tile; reset 0
- busy  out  1  FSM not IDLE, or results still pending; reset 0

## Operation
- FSM states and transitions:
  - IDLE → CLEAR on accept.
  - CLEAR lasts 1 cycle, then → FEED.
  - FEED lasts max(tile_k,1) cycles, then → FLUSH.
  - FLUSH lasts 1 cycle, then → CLEAR on a same-cycle accept, else → IDLE.
- Seeds: clr_seed = (state==CLEAR); en_seed = feed_en = (state==FEED); oen_seed = (state==FLUSH).
- Wavefront: cell(i,j) signal = its seed delayed exactly i+j+1 cycles. One ROWS+COLS-1 stage shift line per seed; cell(i,j) takes stage i+j.
- mode and mult_array_mode register tile_mode and tile_mult on accept. They are stable for the whole tile.
- Result window: oen_seed is delayed COLS+DRAIN_LAT cycles. It then starts a ROWS-cycle stretcher that drives res_valid, with row r result on the r-th cycle. tile_done fires on the last cycle of the window.
- pipe_empty: no oen pulse is in the delay line and the stretcher is idle.
- tile_ready is high only in IDLE or FLUSH, and only when one of these holds:
  - pipe_empty, or
  - tile_mode==mode && tile_mult==mult_array_mode && max(tile_k,1) ≥ ROWS-2.
- The K rule guarantees result windows never overlap. A mode change always waits for a full drain.
- Simultaneous cases:
  - Accept in FLUSH: FLUSH's oen_seed still issues, and CLEAR follows the next cycle.
  - A tile_done pulse in the same cycle as an accept is allowed.
- Reset mid-operation: every register clears asynchronously, all shift lines flush to 0, and no partial res_valid window is emitted. After release the state is IDLE and tile_ready = 1.

## Timing
- Accept at cycle t:
  - mode valid at t+1; CLEAR at t+1.
  - FEED at t+2 … t+1+K; FLUSH at t+2+K.
- cell(i,j) windows:
  - clr at t+2+i+j
  - en at t+3+i+j … t+2+K+i+j
  - out_en at t+3+K+i+j
- res_valid cycles t+2+K+COLS+DRAIN_LAT … plus ROWS-1.
- Tile-to-tile minimum spacing: same mode K+2 cycles; mode change waits until the cycle after tile_done.

## Structure
- Package quan_sa_pkg holds:
  - the FSM state enum (IDLE, CLEAR, FEED, FLUSH)
  - mode encodings (MODE_U8I8=0, MODE_U8T2=1)
  - the cell-index helper i*COLS+j
- Sub-module quan_sa_diag_shift (parameter DEPTH): reset_n-cleared delay line with a seed input and a DEPTH-wide stage output. It is instantiated three times, for clr, en and out_en.
- The fan-out from shift stages to cell bits is pure generate wiring.

## Test plan
- ROWS=COLS=4, DRAIN_LAT=2, K=5, mode 0, accept at cycle 0 →
  - mode=0 at cycle 1
  - cell_clr(0,0) at 2, cell_clr(3,3) at 8
  - cell_en(0,0) at 3–7
  - cell_out_en(0,0) at 8, cell_out_en(3,3) at 14
  - res_valid at 13–16, tile_done at 16
  - tile_ready low at 1–6, high at 7
- Back-to-back same-mode K=5 tile offered from cycle 1 → accepted at 7, CLEAR at 8, res_valid at 20–23, no window overlap.
- Second tile with mode 1 offered at cycle 7 → tile_ready low until 17, accepted at 17, mode=1 at 18.
- ROWS=4, same-mode K=1 tile offered in FLUSH → rejected because 1 < ROWS-2. Accepted at cycle 17 once pipe_empty.
- tile_k=0 → behaves identically to K=1: one cell_en(0,0) cycle.
- reset_n low during FEED → all outputs 0 in the same cycle. After release: no res_valid, tile_ready=1, busy=0.
